// File: rtl/ofs_fim_eth_arb_pkg.sv
// Arbiter state encoding and round-robin pick helper.
package ofs_fim_eth_arb_pkg;

    localparam int unsigned ARB_MAX_SRC  = 8;
    localparam int unsigned ARB_MAX_ID_W = 3;

    typedef logic [0:0] t_tx_arb_state;
    localparam t_tx_arb_state IDLE = 1'b0;
    localparam t_tx_arb_state BUSY = 1'b1;

    // Lowest requester at or above ptr; otherwise wrap to the lowest requester overall.
    function automatic logic [ARB_MAX_ID_W-1:0] rr_pick(
        input logic [ARB_MAX_SRC-1:0]  req,
        input logic [ARB_MAX_ID_W-1:0] ptr
    );
        logic [ARB_MAX_SRC-1:0]  mask;
        logic [ARB_MAX_SRC-1:0]  cand;
        logic [ARB_MAX_ID_W-1:0] win;
        mask = ~((ARB_MAX_SRC'(1) << ptr) - ARB_MAX_SRC'(1));
        cand = req & mask;
        if (cand == '0) cand = req;
        win = '0;
        for (int i = int'(ARB_MAX_SRC) - 1; i >= 0; i--) begin
            if (cand[i]) win = ARB_MAX_ID_W'(i);
        end
        return win;
    endfunction

endpackage

// File: rtl/ofs_fim_eth_if_pkg.sv
// AXIS Ethernet TX beat definition shared by the TX path.
package ofs_fim_eth_if_pkg;

    localparam int unsigned ETH_DATA_W  = 64;
    localparam int unsigned ETH_KEEP_W  = ETH_DATA_W / 8;
    localparam int unsigned ETH_TUSER_W = 2;

    typedef struct packed {
        logic                   tvalid;
        logic                   tlast;
        logic [ETH_DATA_W-1:0]  tdata;
        logic [ETH_KEEP_W-1:0]  tkeep;
        logic [ETH_TUSER_W-1:0] tuser;
    } t_axis_eth_tx;

    localparam int unsigned AXIS_ETH_TX_WIDTH = $bits(t_axis_eth_tx);

endpackage

// File: rtl/ofs_fim_axis_pipeline_reg.sv
// Single-stage AXIS register; ld_c tells the producer a beat can be taken this cycle.
module ofs_fim_axis_pipeline_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         ld_c
);

    assign ld_c = ~out_valid | out_ready;

    // Load on ld; payload only changes when a real beat arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (ld_c) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/ofs_fim_eth_tx_pkt_arb.sv
// Packet-aware round-robin merge of NUM_SRC AXIS Ethernet TX streams onto one MAC channel.
module ofs_fim_eth_tx_pkt_arb
    import ofs_fim_eth_if_pkg::*;
    import ofs_fim_eth_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned SRC_ID_W = $clog2(NUM_SRC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arb_en,
    input  t_axis_eth_tx        src_tx [NUM_SRC],
    output logic [NUM_SRC-1:0]  src_tready,
    output t_axis_eth_tx        out_tx,
    input  logic                out_tready,
    output logic [SRC_ID_W-1:0] grant_id,
    output logic                grant_busy,
    output logic                pkt_done
);

    t_tx_arb_state       state_q;
    t_tx_arb_state       state_d;
    logic [SRC_ID_W-1:0] rr_ptr;
    logic [SRC_ID_W-1:0] rr_d;
    logic [SRC_ID_W-1:0] grant_d;
    logic                done_d;
    logic [NUM_SRC-1:0]  src_valid;
    t_axis_eth_tx        sel_beat;
    logic                accept;
    logic                ld_c;
    logic                pipe_valid;
    t_axis_eth_tx        pipe_data;

    // Gather request vector and the grantee's current beat.
    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) src_valid[i] = src_tx[i].tvalid;
        sel_beat = src_tx[grant_id];
    end

    assign accept     = (state_q == BUSY) & sel_beat.tvalid & ld_c;
    assign grant_busy = (state_q == BUSY);

    // Only the grantee sees ready, and only when the output stage can load.
    always_comb begin
        src_tready = '0;
        if (state_q == BUSY) src_tready[grant_id] = ld_c;
    end

    // Next-state: arbitrate in IDLE, hold the grant until the tlast beat is taken.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_ptr;
        grant_d = grant_id;
        done_d  = accept & sel_beat.tlast;
        case (state_q)
            IDLE: begin
                if (arb_en && (|src_valid)) begin
                    grant_d = SRC_ID_W'(rr_pick(ARB_MAX_SRC'(src_valid), ARB_MAX_ID_W'(rr_ptr)));
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_beat.tlast) begin
                    state_d = IDLE;
                    rr_d    = (grant_id == SRC_ID_W'(NUM_SRC - 1)) ? '0 : grant_id + SRC_ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            pkt_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_d;
            grant_id <= grant_d;
            pkt_done <= done_d;
        end
    end

    ofs_fim_axis_pipeline_reg #(
        .W (AXIS_ETH_TX_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (sel_beat),
        .out_ready (out_tready),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .ld_c      (ld_c)
    );

    // Registered payload with the stage's own valid bit.
    always_comb begin
        out_tx        = pipe_data;
        out_tx.tvalid = pipe_valid;
    end

endmodule

// File: tb/tb_ofs_fim_eth_tx_pkt_arb.sv
// Bench for the TX packet arbiter: behavioural reference model, directed scenarios, random traffic.
module tb_ofs_fim_eth_tx_pkt_arb;
    import ofs_fim_eth_if_pkg::*;

    localparam int unsigned NUM_SRC  = 4;
    localparam int unsigned SRC_ID_W = 2;
    localparam int          N        = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                arb_en;
    t_axis_eth_tx        src_tx [NUM_SRC];
    logic [NUM_SRC-1:0]  src_tready;
    t_axis_eth_tx        out_tx;
    logic                out_tready;
    logic [SRC_ID_W-1:0] grant_id;
    logic                grant_busy;
    logic                pkt_done;

    always #5 clk = ~clk;

    ofs_fim_eth_tx_pkt_arb #(.NUM_SRC(NUM_SRC), .SRC_ID_W(SRC_ID_W)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .src_tx(src_tx), .src_tready(src_tready),
        .out_tx(out_tx), .out_tready(out_tready), .grant_id(grant_id),
        .grant_busy(grant_busy), .pkt_done(pkt_done)
    );

    typedef struct { t_axis_eth_tx beat; int gap; } item_t;
    item_t srcq [N][$];
    bit    pres [N];
    bit    rand_mode = 0;
    int    vecs = 0;
    int    errs = 0;

    // Reference model: who owns the channel, RR pointer, contents of the output slot.
    bit           m_busy;
    int           m_gid;
    int           m_rr;
    bit           m_ov;
    t_axis_eth_tx m_obeat;
    bit           m_done;

    int           glog[$];
    logic [63:0]  dlog[$];
    int           busy_cnt = 0;
    bit           prev_busy = 0;
    bit           prev_stall = 0;
    t_axis_eth_tx prev_out;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_gid = 0; m_rr = 0; m_ov = 0; m_obeat = '0; m_done = 0;
    endfunction

    task automatic add_pkt(int s, int len, logic [63:0] base, int first_gap, int gap_after, int gap_len);
        item_t it;
        for (int b = 0; b < len; b++) begin
            it.beat        = '0;
            it.beat.tvalid = 1'b1;
            it.beat.tlast  = (b == len - 1);
            it.beat.tdata  = base + 64'(b);
            it.beat.tkeep  = 8'($urandom);
            it.beat.tuser  = 2'($urandom);
            it.gap         = (b == 0) ? first_gap : ((b == gap_after + 1) ? gap_len : 0);
            srcq[s].push_back(it);
        end
    endtask

    // One clock: drive sources, check DUT against the model, advance model and sources.
    task automatic cycle();
        item_t           it;
        bit              ld;
        bit              acc;
        bit              found;
        logic [N-1:0]    exp_rdy;
        t_axis_eth_tx    exp_out;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && srcq[i].size() > 0) begin
                if (srcq[i][0].gap > 0) begin
                    it = srcq[i][0]; it.gap--; srcq[i][0] = it;
                end else if (!rand_mode || $urandom_range(99) < 70) begin
                    pres[i] = 1;
                end
            end
            src_tx[i]        = (srcq[i].size() > 0) ? srcq[i][0].beat : '0;
            src_tx[i].tvalid = pres[i];
        end
        #1;
        ld      = !m_ov || out_tready;
        exp_rdy = '0;
        if (m_busy && ld) exp_rdy[m_gid] = 1'b1;
        exp_out        = m_obeat;
        exp_out.tvalid = m_ov;
        chk("out_tx", 128'(out_tx), 128'(exp_out));
        chk("src_tready", 128'(src_tready), 128'(exp_rdy));
        chk("grant_busy", 128'(grant_busy), 128'(m_busy));
        chk("grant_id", 128'(grant_id), 128'(m_gid));
        chk("pkt_done", 128'(pkt_done), 128'(m_done));
        if (prev_stall) chk("stall_hold", 128'(out_tx), 128'(prev_out));
        prev_stall = out_tx.tvalid && !out_tready && !rst;
        prev_out   = out_tx;
        if (grant_busy && !prev_busy) glog.push_back(int'(grant_id));
        prev_busy = grant_busy;
        if (grant_busy) busy_cnt++;
        if (out_tx.tvalid && out_tready) dlog.push_back(out_tx.tdata);
        if (rst) begin
            model_reset();
        end else begin
            acc = m_busy && src_tx[m_gid].tvalid && ld;
            if (ld) begin
                m_ov = acc;
                if (acc) m_obeat = src_tx[m_gid];
            end
            m_done = acc && src_tx[m_gid].tlast;
            if (!m_busy) begin
                found = 0;
                if (arb_en) begin
                    for (int k = 0; k < N; k++) begin
                        if (!found && src_tx[(m_rr + k) % N].tvalid) begin
                            found = 1; m_gid = (m_rr + k) % N; m_busy = 1;
                        end
                    end
                end
            end else if (acc && src_tx[m_gid].tlast) begin
                m_busy = 0;
                m_rr   = (m_gid + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pres[i] && src_tready[i]) begin
                void'(srcq[i].pop_front());
                pres[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain(int maxc);
        int  c;
        bit  pend;
        c = 0;
        pend = 1;
        while (pend && c < maxc) begin
            cycle();
            c++;
            pend = grant_busy || out_tx.tvalid;
            for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pend = 1;
        end
        if (pend) begin
            vecs++; errs++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", maxc);
        end
    endtask

    task automatic chk_glog(string name, int exp[$]);
        chk({name, "_count"}, 128'(glog.size()), 128'(exp.size()));
        for (int k = 0; k < exp.size() && k < glog.size(); k++)
            chk(name, 128'(glog[k]), 128'(exp[k]));
        glog.delete();
    endtask

    initial begin
        int n_done;
        int pat[4];
        rst = 1; arb_en = 1; out_tready = 1;
        for (int i = 0; i < N; i++) begin src_tx[i] = '0; pres[i] = 0; end
        @(posedge clk); #1;
        model_reset();

        // Reset with every source requesting, then fairness over 3-beat packets.
        for (int s = 0; s < N; s++) begin
            add_pkt(s, 3, 64'h100 * s, 0, -1, 0);
            add_pkt(s, 3, 64'h100 * s + 64'h10, 0, -1, 0);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rst_tvalid", 128'(out_tx.tvalid), 128'(0));
            chk("rst_tready", 128'(src_tready), 128'(0));
            chk("rst_grant_id", 128'(grant_id), 128'(0));
        end
        glog.delete();
        rst = 0;
        n_done = 0;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            if (k == 1) begin
                chk("first_grant_busy", 128'(grant_busy), 128'(1));
                chk("first_grant_id", 128'(grant_id), 128'(0));
            end
            if (pkt_done) n_done++;
        end
        chk("pkt_done_in_16", 128'(n_done), 128'(4));
        drain(200);
        chk_glog("fair_order", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Backpressure on a 5-beat packet from src2.
        pat = '{1, 0, 0, 1};
        dlog.delete();
        add_pkt(2, 5, 64'hA0, 0, -1, 0);
        for (int k = 0; k < 40; k++) begin
            out_tready = pat[k % 4][0];
            cycle();
        end
        out_tready = 1;
        chk("bp_beats", 128'(dlog.size()), 128'(5));
        for (int k = 0; k < 5 && k < dlog.size(); k++) chk("bp_tdata", 128'(dlog[k]), 128'(64'hA0 + 64'(k)));
        glog.delete();

        // src1 stalls mid-packet; src3 must wait for its tlast.
        add_pkt(1, 4, 64'h10, 0, 1, 4);
        add_pkt(3, 2, 64'h30, 2, -1, 0);
        drain(200);
        chk_glog("stall_order", '{1, 3});

        // arb_en dropped inside src0's packet.
        add_pkt(0, 3, 64'h50, 0, -1, 0);
        add_pkt(1, 2, 64'h60, 0, -1, 0);
        run(2);
        arb_en = 0;
        run(14);
        chk("en_off_busy", 128'(grant_busy), 128'(0));
        chk("en_off_outvalid", 128'(out_tx.tvalid), 128'(0));
        arb_en = 1;
        drain(200);
        chk_glog("enable_order", '{0, 1});

        // Single-beat packet from src3, then rr_ptr wrap to src0.
        busy_cnt = 0;
        add_pkt(3, 1, 64'h3A, 0, -1, 0);
        drain(200);
        chk("single_beat_busy", 128'(busy_cnt), 128'(1));
        add_pkt(0, 2, 64'h70, 0, -1, 0);
        add_pkt(3, 2, 64'h80, 0, -1, 0);
        drain(200);
        chk_glog("wrap_order", '{3, 0, 3});

        // Random traffic, backpressure, enable toggling and occasional reset.
        rand_mode = 1;
        for (int k = 0; k < 4000; k++) begin
            out_tready = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 2) arb_en = ~arb_en;
            rst = ($urandom_range(999) < 3);
            for (int s = 0; s < N; s++)
                if (srcq[s].size() < 2 && $urandom_range(99) < 20)
                    add_pkt(s, $urandom_range(6, 1), 64'($urandom) << 8, $urandom_range(3), -1, 0);
            cycle();
        end
        rand_mode = 0; rst = 0; arb_en = 1; out_tready = 1;
        drain(500);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ofs_fim_eth_tx_pkt_arb.md
Name: ofs_fim_eth_tx_pkt_arb

Overview:
- Packet-aware round-robin arbiter. Merges NUM_SRC AFU-side AXIS Ethernet TX streams (t_axis_eth_tx) onto one TX channel toward the MAC.
- A grant is held from the first beat of a packet to its tlast, so packets never interleave.
- Sits between AFU TX clients and the per-channel HSSI TX port.
- Has a registered output stage and an enable for quiescing traffic.

Parameters:
- NUM_SRC, 4, number of requesting TX streams (2..8).
- SRC_ID_W, $clog2(NUM_SRC), width of the grant index.

Ports:
- clk  in  1  clock; all ports synchronous to it.
- rst  in  1  synchronous, active-high reset.
- arb_en  in  1  1 = new grants allowed; 0 = finish the current packet, then issue no new grant.
- src_tx  in  NUM_SRC x AXIS_ETH_TX_WIDTH  array of t_axis_eth_tx (tvalid, tlast, tdata, tkeep, tuser).
- src_tready  out  NUM_SRC  per-source ready.
- out_tx  out  AXIS_ETH_TX_WIDTH  merged t_axis_eth_tx toward the MAC.
- out_tready  in  1  MAC ready.
- grant_id  out  SRC_ID_W  index of the current/last grantee.
- grant_busy  out  1  1 while in BUSY.
- pkt_done  out  1  one-cycle pulse when a tlast beat is accepted from a source.

Behaviour:
- Reset values (applied when rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0, grant_busy=0, pkt_done=0.
  - out_tx.tvalid=0; tlast, tdata, tkeep and tuser cleared to 0.
  - src_tready combinationally 0 while in IDLE.
- Reset mid-packet: the partial packet is abandoned. No tlast is generated; downstream recovery is the MAC's responsibility.
- Output register:
  - ld = ~out_tx.tvalid | out_tready.
  - When ld, out_tx loads the selected source beat if that source has tvalid & src_tready. Otherwise out_tx.tvalid clears.
  - out_tx holds stable while out_tx.tvalid & ~out_tready (AXIS rule).
  - Input-to-output latency: 1 cycle.
- State machine:
  - IDLE:
    - If arb_en and any src_tx[i].tvalid: choose the first valid i scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
    - Register grant_id=i and go to BUSY. No beat is transferred in the arbitration cycle.
    - src_tready=0.
  - BUSY:
    - src_tready[grant_id]=ld; all other src_tready bits are 0.
    - On an accepted beat (src_tvalid & src_tready) with tlast: pkt_done=1 the next cycle, rr_ptr=(grant_id+1) mod NUM_SRC, go to IDLE.
    - Non-tlast beats stay in BUSY.
- Fairness: back-to-back packets from different sources are separated by exactly one idle arbitration cycle. With all sources valid, grants go 0,1,2,3,0,...
- Boundary conditions:
  - The grantee deasserting tvalid mid-packet keeps the grant; there is no timeout.
  - arb_en dropped in BUSY has no effect until tlast.
  - A single-beat packet (tvalid & tlast on the first beat) takes one BUSY cycle.
  - Only one valid source: it is re-granted after each packet, with a 1-cycle gap.
  - tlast accepted while out_tready=0 and the output register is full cannot happen, because ld gates acceptance.
  - rr_ptr wrap: NUM_SRC-1 → 0.
  - A request from the current grantee arriving in the IDLE cycle competes normally from the updated rr_ptr.
- tuser and tkeep pass through unmodified. The block does no tkeep compaction or checking.

Decomposition:
- ofs_fim_eth_if_pkg (existing): t_axis_eth_tx and AXIS_ETH_TX_WIDTH.
- New shared package ofs_fim_eth_arb_pkg holds:
  - state enum t_tx_arb_state {IDLE, BUSY};
  - function to pick the round-robin winner (one-hot mask plus rotate).
- One sub-module, ofs_fim_axis_pipeline_reg: the single-stage AXIS output register with ld logic, reusable elsewhere.

Test Plan:
- Reset check: hold rst=1 for 3 clks with all src valid → out_tx.tvalid=0, src_tready=0, grant_id=0. Release rst → first grant goes to src 0 in the next cycle.
- Fairness: 4 sources each send 3-beat packets continuously, out_tready=1 → output order src0,1,2,3,0. Each packet is 3 contiguous beats with 1 gap cycle between packets. pkt_done pulses 4 times in 16 cycles.
- Backpressure: src2 sends 5 beats while out_tready toggles 1,0,0,1,... → no beat lost or duplicated. out_tx is stable during every stalled cycle. tdata sequence 0xA0..0xA4 is preserved.
- Mid-packet stall: src1 drops tvalid for 4 cycles after beat 2, while src3 is valid → src3 is not granted until src1's tlast. src3's packet then follows after 1 idle cycle.
- Enable: drop arb_en during src0's packet → that packet completes. With arb_en=0 no new grant is issued for 10 cycles despite requests. Re-enable → src1 is granted (rr_ptr=1).
- Single-beat and wrap: src3 sends a 1-beat packet (tlast on its first beat) → one BUSY cycle. Next, src0 and src3 both valid → src0 granted (rr_ptr wrapped 3→0).
